ps2_scancode_rx: RTL and testbench
==================================

# ps2_scancode_rx

Validated PS/2 keyboard receiver that sits directly downstream of the raw `ps2_clk`/`ps2_dat` pins. It frames each 11-bit packet, checks the start, parity and stop bits, and recovers from stalled frames with a watchdog. It presents raw bytes, then folds the `E0` (extended) and `F0` (break) prefixes into a single decoded key event for the display and LED logic above it.

## Interface
- `TIMEOUT_CYCLES`, default 50000: CLOCK_50 cycles allowed between ps2_clk falling edges inside a frame (1 ms at 50 MHz).
- `CLOCK_50`  in  1  system clock; all logic on the rising edge.
- `Resetn`  in  1  reset; one clock, reset is synchronous and active-low.
- `ps2_clk`  in  1  PS/2 clock, asynchronous; receive only, never driven.
- `ps2_dat`  in  1  PS/2 data, asynchronous; receive only, never driven.
- `byte_data`  out  8  last good byte; holds until the next good byte.
- `byte_valid`  out  1  one-cycle pulse per good frame.
- `parity_err`  out  1  one-cycle pulse on an odd-parity failure.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit or a watchdog timeout.
- `code`  out  8  last decoded non-prefix scancode.
- `code_break`  out  1  `code` was preceded by `F0`.
- `code_ext`  out  1  `code` was preceded by `E0`.
- `code_valid`  out  1  one-cycle pulse per decoded key event.

## Operation
- **Input conditioning:** two-flop synchroniser on each input, plus a `prev` register on the synchronised clock.
  - `fall = prev & ~clk_s`.
  - Only `fall` cycles sample `dat_s`.
- **FSM states:** IDLE, DATA, PARITY, STOP.
  - **IDLE:** on `fall` with `dat_s=0`, clear the shifter and `bit_cnt`, go to DATA. On `fall` with `dat_s=1`, stay in IDLE; no error.
  - **DATA:** shift right, LSB first. After the 8th bit go to PARITY.
  - **PARITY:** latch the parity bit, go to STOP.
  - **STOP:** always return to IDLE.
    - Stop=1 and ones(data)+parity odd: good frame.
    - Stop=1 and parity fails: `parity_err`.
    - Stop=0: `frame_err`; this takes precedence over the parity check.
- **Watchdog:**
  - Counter clears on every `fall` and in IDLE.
  - In DATA/PARITY/STOP, reaching `TIMEOUT_CYCLES-1` pulses `frame_err`, discards the partial frame, and goes to IDLE.
  - If `fall` and timeout coincide, `fall` wins.
- **Prefix decoder (good frames only):**
  - `E0` sets `ext_pend`.
  - `F0` sets `brk_pend`.
  - Any other byte loads `code`, `code_ext=ext_pend`, `code_break=brk_pend`, pulses `code_valid`, and clears both pending flags.
  - Any `parity_err` or `frame_err` clears both pending flags.
  - Prefix bytes still pulse `byte_valid`.
- **Reset:**
  - All outputs, the pending flags, the counter and `bit_cnt` go to 0; FSM goes to IDLE; synchronisers go to 1 (idle bus).
  - Reset mid-frame discards the frame with no error pulse.

## Timing
- A pin transition is visible in `clk_s` after 2 edges; `fall` acts on the 3rd edge.
- `byte_valid`, `code_valid` and the error pulses are registered and assert for exactly one cycle after the 3rd CLOCK_50 edge that samples the stop-bit falling edge.
- `byte_data`, `code` and the flags update on the same edge as their strobe.
- `code_valid` coincides with `byte_valid` for the same frame; it is never asserted alone.
- At most one of `byte_valid`/`parity_err`/`frame_err` asserts in any cycle.
- Watchdog width: `$clog2(TIMEOUT_CYCLES)` bits.

## Structure
- `ps2_defs.vh` (shared include):
  - FSM state encodings.
  - `PS2_PREFIX_EXT = 8'hE0`, `PS2_PREFIX_BRK = 8'hF0`.
  - `PS2_FRAME_BITS = 11`.
- Sub-module `ps2_sync_edge`: synchroniser + `prev` + `fall` output. It is reusable by a future PS/2 transmitter.
- The FSM, watchdog and prefix decoder stay in `ps2_scancode_rx`.

## Test plan
- Bench uses `TIMEOUT_CYCLES=200` and a PS/2 clock with 40 CLOCK_50 cycles per bit.
1. Reset, then frame `1C` (parity 0, stop 1) → one `byte_valid`, `byte_data=1C`; one `code_valid`, `code=1C`, break=0, ext=0.
2. Frames `F0`,`1C` → two `byte_valid`; a single `code_valid` with `code=1C`, break=1, ext=0.
3. Frames `E0`,`F0`,`75` → three `byte_valid`; a single `code_valid` with `code=75`, ext=1, break=1.
4. Frame `1C` with parity 1 → `parity_err` pulse, no `byte_valid`. Then `5A` (parity 1) → `byte_data=5A`, `code_valid`.
5. Frame `5A` with stop 0 → `frame_err`. Then `E0` followed by 4 bits and a stall → `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall`, `ext_pend` cleared. Then `1C` → `code_ext=0`.
6. `E0`, then `Resetn=0` for 1 cycle mid-frame after 5 bits → all outputs 0, no error pulse. Then `5A` → `code=5A`, ext=0.

Source files
------------

// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scancode receiver: FSM encoding, frame
// geometry, prefix bytes and the odd-parity helper.
package ps2_scancode_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    // PS/2 uses odd parity: data ones plus the parity bit must be odd.
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for the PS/2 clock and data pins, with a delayed
// copy of the synchronised clock to detect its falling edge. Kept separate
// so a future transmitter can share the same conditioning.
module ps2_sync_edge (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic dat_s,
    output logic fall
);

    logic clk_meta_r;
    logic clk_sync_r;
    logic clk_prev_r;
    logic dat_meta_r;
    logic dat_sync_r;

    // Synchronise both pins and keep the previous synchronised clock; reset to idle-bus high.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            clk_prev_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            clk_prev_r <= clk_sync_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    assign dat_s = dat_sync_r;
    assign fall  = clk_prev_r & ~clk_sync_r;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames 11-bit packets, validates start/parity/stop,
// aborts stalled frames with a watchdog, and folds E0/F0 prefixes into a
// single decoded key event.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       code_valid
);

    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_ONE  = WDOG_W'(1);
    localparam logic [2:0]        LAST_BIT  = 3'(PS2_DATA_BITS - 1);

    logic              dat_s;
    logic              fall_s;
    logic              timeout_s;

    ps2_state_e        state_r,    state_nxt_s;
    logic [7:0]        shift_r,    shift_nxt_s;
    logic [2:0]        bit_cnt_r,  bit_cnt_nxt_s;
    logic              par_r,      par_nxt_s;
    logic [WDOG_W-1:0] wdog_r,     wdog_nxt_s;
    logic              ext_pend_r, ext_pend_nxt_s;
    logic              brk_pend_r, brk_pend_nxt_s;

    logic [7:0]        byte_data_nxt_s;
    logic              byte_valid_nxt_s;
    logic              parity_err_nxt_s;
    logic              frame_err_nxt_s;
    logic [7:0]        code_nxt_s;
    logic              code_break_nxt_s;
    logic              code_ext_nxt_s;
    logic              code_valid_nxt_s;

    ps2_sync_edge u_sync (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .dat_s    (dat_s),
        .fall     (fall_s)
    );

    assign timeout_s = (wdog_r == WDOG_LAST);

    // Next-state, watchdog, frame checking and prefix decoding.
    always_comb begin
        state_nxt_s      = state_r;
        shift_nxt_s      = shift_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        par_nxt_s        = par_r;
        wdog_nxt_s       = wdog_r;
        ext_pend_nxt_s   = ext_pend_r;
        brk_pend_nxt_s   = brk_pend_r;
        byte_data_nxt_s  = byte_data;
        byte_valid_nxt_s = 1'b0;
        parity_err_nxt_s = 1'b0;
        frame_err_nxt_s  = 1'b0;
        code_nxt_s       = code;
        code_break_nxt_s = code_break;
        code_ext_nxt_s   = code_ext;
        code_valid_nxt_s = 1'b0;

        if (state_r == ST_IDLE) begin
            // A high bit on a falling edge while idle is line noise, not an error.
            wdog_nxt_s = '0;
            if (fall_s && !dat_s) begin
                shift_nxt_s   = 8'h00;
                bit_cnt_nxt_s = 3'd0;
                state_nxt_s   = ST_DATA;
            end else begin
                state_nxt_s = ST_IDLE;
            end
        end else if (!fall_s) begin
            // No edge this cycle: advance the watchdog or abort a stalled frame.
            if (timeout_s) begin
                frame_err_nxt_s = 1'b1;
                ext_pend_nxt_s  = 1'b0;
                brk_pend_nxt_s  = 1'b0;
                wdog_nxt_s      = '0;
                state_nxt_s     = ST_IDLE;
            end else begin
                wdog_nxt_s = wdog_r + WDOG_ONE;
            end
        end else begin
            // A falling edge always beats a coincident timeout.
            wdog_nxt_s = '0;
            case (state_r)
                ST_DATA: begin
                    shift_nxt_s = {dat_s, shift_r[7:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = ST_PARITY;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                    end
                end
                ST_PARITY: begin
                    par_nxt_s   = dat_s;
                    state_nxt_s = ST_STOP;
                end
                ST_STOP: begin
                    state_nxt_s = ST_IDLE;
                    if (!dat_s) begin
                        frame_err_nxt_s = 1'b1;
                        ext_pend_nxt_s  = 1'b0;
                        brk_pend_nxt_s  = 1'b0;
                    end else if (!frame_parity_ok(shift_r, par_r)) begin
                        parity_err_nxt_s = 1'b1;
                        ext_pend_nxt_s   = 1'b0;
                        brk_pend_nxt_s   = 1'b0;
                    end else begin
                        byte_valid_nxt_s = 1'b1;
                        byte_data_nxt_s  = shift_r;
                        if (shift_r == PS2_PREFIX_EXT) begin
                            ext_pend_nxt_s = 1'b1;
                        end else if (shift_r == PS2_PREFIX_BRK) begin
                            brk_pend_nxt_s = 1'b1;
                        end else begin
                            code_nxt_s       = shift_r;
                            code_ext_nxt_s   = ext_pend_r;
                            code_break_nxt_s = brk_pend_r;
                            code_valid_nxt_s = 1'b1;
                            ext_pend_nxt_s   = 1'b0;
                            brk_pend_nxt_s   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; synchronous active-low reset drops any partial frame silently.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_r    <= ST_IDLE;
            shift_r    <= 8'h00;
            bit_cnt_r  <= 3'd0;
            par_r      <= 1'b0;
            wdog_r     <= '0;
            ext_pend_r <= 1'b0;
            brk_pend_r <= 1'b0;
            byte_data  <= 8'h00;
            byte_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            code       <= 8'h00;
            code_break <= 1'b0;
            code_ext   <= 1'b0;
            code_valid <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            par_r      <= par_nxt_s;
            wdog_r     <= wdog_nxt_s;
            ext_pend_r <= ext_pend_nxt_s;
            brk_pend_r <= brk_pend_nxt_s;
            byte_data  <= byte_data_nxt_s;
            byte_valid <= byte_valid_nxt_s;
            parity_err <= parity_err_nxt_s;
            frame_err  <= frame_err_nxt_s;
            code       <= code_nxt_s;
            code_break <= code_break_nxt_s;
            code_ext   <= code_ext_nxt_s;
            code_valid <= code_valid_nxt_s;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Testbench for ps2_scancode_rx: directed scenarios followed by random
// frames, compared against a frame-level model of the receiver.
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       CLOCK_50 = 1'b0;
    logic       Resetn;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       parity_err;
    logic       frame_err;
    logic [7:0] code;
    logic       code_break;
    logic       code_ext;
    logic       code_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor captures
    int         n_bv = 0;
    int         n_pe = 0;
    int         n_fe = 0;
    int         n_cv = 0;
    logic [7:0] cap_byte = 8'h00;
    logic [7:0] cap_code = 8'h00;
    logic       cap_brk  = 1'b0;
    logic       cap_ext  = 1'b0;
    int         ferr_cyc = 0;
    int         last_fall_cyc = 0;

    // Reference model state
    logic [7:0] m_byte;
    logic [7:0] m_code;
    logic       m_code_brk;
    logic       m_code_ext;
    logic       m_ext;
    logic       m_brk;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .code       (code),
        .code_break (code_break),
        .code_ext   (code_ext),
        .code_valid (code_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Record strobes on the inactive edge and check pulse exclusivity.
    always @(negedge CLOCK_50) begin
        if (byte_valid) begin
            n_bv     <= n_bv + 1;
            cap_byte <= byte_data;
        end
        if (parity_err) n_pe <= n_pe + 1;
        if (frame_err) begin
            n_fe     <= n_fe + 1;
            ferr_cyc <= cyc;
        end
        if (code_valid) begin
            n_cv     <= n_cv + 1;
            cap_code <= code;
            cap_brk  <= code_break;
            cap_ext  <= code_ext;
        end
        if (byte_valid || parity_err || frame_err || code_valid) begin
            check_value("pulse_excl", 32'($countones({byte_valid, parity_err, frame_err}) <= 1), 32'd1);
            if (code_valid) check_value("cv_with_bv", 32'(byte_valid), 32'd1);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic send_bit(input logic b);
        wait_cyc(1);
        ps2_dat = b;
        wait_cyc(HALF - 1);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic model_reset();
        m_byte = 8'h00; m_code = 8'h00; m_code_brk = 1'b0; m_code_ext = 1'b0;
        m_ext = 1'b0; m_brk = 1'b0;
    endtask

    // Send the first nbits of a frame and check the outcome against the model.
    task automatic run_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        int b_bv, b_pe, b_fe, b_cv;
        bit good, pe, fe, cv;
        bits[0]   = 1'b0;
        bits[8:1] = d;
        bits[9]   = (($countones(d) % 2) == 0) ^ bad_par;
        bits[10]  = ~bad_stop;
        b_bv = n_bv; b_pe = n_pe; b_fe = n_fe; b_cv = n_cv;
        for (int i = 0; i < nbits; i++) send_bit(bits[i]);
        ps2_dat = 1'b1;
        if (nbits < 11) wait_cyc(TIMEOUT + 30);
        else            wait_cyc(10);

        good = (nbits == 11) && bits[10] && (($countones(bits[9:1]) % 2) == 1);
        pe   = (nbits == 11) && bits[10] && !good;
        fe   = !good && !pe;
        cv   = 1'b0;
        if (good) begin
            m_byte = d;
            if (d == 8'hE0)      m_ext = 1'b1;
            else if (d == 8'hF0) m_brk = 1'b1;
            else begin
                cv = 1'b1;
                m_code = d; m_code_ext = m_ext; m_code_brk = m_brk;
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end else begin
            m_ext = 1'b0; m_brk = 1'b0;
        end

        check_value("bv_count", 32'(n_bv - b_bv), 32'(good));
        check_value("pe_count", 32'(n_pe - b_pe), 32'(pe));
        check_value("fe_count", 32'(n_fe - b_fe), 32'(fe));
        check_value("cv_count", 32'(n_cv - b_cv), 32'(cv));
        if (good) check_value("bv_byte", 32'(cap_byte), 32'(d));
        if (cv) begin
            check_value("cv_code", 32'(cap_code), 32'(d));
            check_value("cv_brk",  32'(cap_brk), 32'(m_code_brk));
            check_value("cv_ext",  32'(cap_ext), 32'(m_code_ext));
        end
        check_value("byte_hold", 32'(byte_data), 32'(m_byte));
        check_value("code_hold", 32'({code_ext, code_break, code}), 32'({m_code_ext, m_code_brk, m_code}));
    endtask

    initial begin
        int b_pe, b_fe, r, e, nb;
        logic [7:0] d;
        bit bp, bs;

        Resetn  = 1'b0;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        model_reset();
        wait_cyc(5);
        Resetn = 1'b1;
        wait_cyc(5);
        check_value("rst_outs", 32'({byte_data, code, code_break, code_ext}), 32'd0);
        check_value("rst_pulses", 32'({byte_valid, parity_err, frame_err, code_valid}), 32'd0);

        // 1: plain make code
        run_frame(8'h1C, 1'b0, 1'b0, 11);
        // 2: break
        run_frame(8'hF0, 1'b0, 1'b0, 11);
        run_frame(8'h1C, 1'b0, 1'b0, 11);
        // 3: extended break
        run_frame(8'hE0, 1'b0, 1'b0, 11);
        run_frame(8'hF0, 1'b0, 1'b0, 11);
        run_frame(8'h75, 1'b0, 1'b0, 11);
        // 4: parity error, then recovery
        run_frame(8'h1C, 1'b1, 1'b0, 11);
        run_frame(8'h5A, 1'b0, 1'b0, 11);
        // 5: bad stop (also with bad parity: stop wins), stall with timeout
        run_frame(8'h5A, 1'b0, 1'b1, 11);
        run_frame(8'h1C, 1'b1, 1'b1, 11);
        run_frame(8'hE0, 1'b0, 1'b0, 11);
        run_frame(8'hE0, 1'b0, 1'b0, 5);
        check_value("wdog_latency", 32'(ferr_cyc - last_fall_cyc), 32'(TIMEOUT + 3));
        run_frame(8'h1C, 1'b0, 1'b0, 11);
        // 6: reset mid-frame
        run_frame(8'hE0, 1'b0, 1'b0, 11);
        b_pe = n_pe; b_fe = n_fe;
        for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'b1);
        wait_cyc(2);
        Resetn = 1'b0;
        wait_cyc(1);
        Resetn = 1'b1;
        model_reset();
        wait_cyc(3);
        check_value("midrst_outs", 32'({byte_data, code, code_break, code_ext}), 32'd0);
        ps2_dat = 1'b1;
        wait_cyc(TIMEOUT + 30);
        check_value("midrst_no_err", 32'((n_pe - b_pe) + (n_fe - b_fe)), 32'd0);
        run_frame(8'h5A, 1'b0, 1'b0, 11);

        // Random frames
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      d = 8'hE0;
            else if (r == 1) d = 8'hF0;
            else             d = 8'($urandom_range(0, 255));
            e  = $urandom_range(0, 9);
            bp = (e == 0) || (e == 3);
            bs = (e == 1) || (e == 3);
            nb = (e == 2) ? $urandom_range(1, 10) : 11;
            run_frame(d, bp, bs, nb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
